// File: rtl/arm_if_pkg.sv
// Shared definitions for the instruction-fetch stage and the IF/ID pipeline
// register consumed by the decode stage.
package arm_if_pkg;

   localparam int unsigned WORD_W = 32;
   localparam logic [WORD_W-1:0] PC_INC = 32'd4;
   localparam logic [WORD_W-1:0] DEF_NOP_INSTR = 32'h0000_0000;
   localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;

   // IF/ID bundle: pc holds the captured instruction's address + 4.
   typedef struct packed {
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] instr;
      logic              valid;
   } if_id_t;

   // Word-align a byte address by clearing its two low bits.
   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] adr);
      return adr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/if_fetch_stage_pc_reg.sv
// Program-counter register: synchronous reset to RST_VAL, load-enabled update.
module pc_reg
   import arm_if_pkg::*;
#(
   parameter logic [WORD_W-1:0] RST_VAL = DEF_RESET_PC
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_en_i,
   input  logic [WORD_W-1:0] load_data_i,
   output logic [WORD_W-1:0] pc_o
);

   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_d;

   // Next value: load when enabled, otherwise hold.
   always_comb begin
      pc_d = pc_q;
      if (load_en_i) begin
         pc_d = load_data_i;
      end
   end

   // Reset has priority over any load.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc_q <= RST_VAL;
      end else begin
         pc_q <= pc_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address
// and captures the returned word into the IF/ID register. Handles freeze from
// the hazard unit and branch redirect/flush from EX (branch beats freeze).
// Optional build macro IF_PERF_CNT_EN adds fetch and flush event counters.
module if_fetch_stage
   import arm_if_pkg::*;
#(
   parameter logic [WORD_W-1:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [WORD_W-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              branch_taken,
   input  logic [WORD_W-1:0] branch_adr,
   output logic [WORD_W-1:0] inst_adr,
   input  logic [WORD_W-1:0] inst_data,
   output logic [WORD_W-1:0] if_pc,
   output logic [WORD_W-1:0] if_instr,
   output logic              if_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [WORD_W-1:0] perf_fetch_cnt,
   output logic [WORD_W-1:0] perf_flush_cnt
`endif
);

   logic [WORD_W-1:0] pc_q;
   logic [WORD_W-1:0] pc_inc;
   logic [WORD_W-1:0] pc_load_data;
   logic              pc_load_en;
   logic              advance;
   if_id_t            if_id_q;
   if_id_t            if_id_d;

   // A normal advance happens only when neither redirect nor stall is active.
   assign advance = !branch_taken && !freeze;
   // Wraps naturally modulo 2^32.
   assign pc_inc  = pc_q + PC_INC;

   // Next-PC select: branch target (aligned) or sequential; freeze holds.
   always_comb begin
      pc_load_en   = branch_taken || !freeze;
      pc_load_data = pc_inc;
      if (branch_taken) begin
         pc_load_data = word_align(branch_adr);
      end
   end

   pc_reg #(
      .RST_VAL (word_align(RESET_PC))
   ) u_pc_reg (
      .clk_i       (clk),
      .rst_i       (rst),
      .load_en_i   (pc_load_en),
      .load_data_i (pc_load_data),
      .pc_o        (pc_q)
   );

   // Memory address is the raw PC with no logic in the path.
   assign inst_adr = pc_q;

   // IF/ID next state: flush on branch, capture on advance, else hold.
   always_comb begin
      if_id_d = if_id_q;
      if (branch_taken) begin
         if_id_d.pc    = '0;
         if_id_d.instr = NOP_INSTR;
         if_id_d.valid = 1'b0;
      end else if (!freeze) begin
         if_id_d.pc    = pc_inc;
         if_id_d.instr = inst_data;
         if_id_d.valid = 1'b1;
      end
   end

   // IF/ID register; reset loads an empty slot holding the NOP word.
   always_ff @(posedge clk) begin
      if (rst) begin
         if_id_q.pc    <= '0;
         if_id_q.instr <= NOP_INSTR;
         if_id_q.valid <= 1'b0;
      end else begin
         if_id_q <= if_id_d;
      end
   end

   assign if_pc    = if_id_q.pc;
   assign if_instr = if_id_q.instr;
   assign if_valid = if_id_q.valid;

`ifdef IF_PERF_CNT_EN
   logic [WORD_W-1:0] fetch_cnt_q;
   logic [WORD_W-1:0] fetch_cnt_d;
   logic [WORD_W-1:0] flush_cnt_q;
   logic [WORD_W-1:0] flush_cnt_d;

   // Count advances and redirects; both wrap modulo 2^32.
   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (advance) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end
      if (branch_taken) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
   end

   // Counter registers cleared on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Self-checking bench for if_fetch_stage with a behavioural fetch model.
module tb_if_fetch_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0000;

   logic        clk;
   logic        rst;
   logic        freeze;
   logic        branch_taken;
   logic [31:0] branch_adr;
   logic [31:0] inst_adr;
   logic [31:0] inst_data;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   int tests;
   int fails;

   // Reference model state
   logic [31:0] m_pc;
   logic [31:0] m_ifpc;
   logic [31:0] m_instr;
   logic        m_valid;
   int unsigned m_fetch;
   int unsigned m_flush;

   if_fetch_stage #(
      .RESET_PC  (RST_PC),
      .NOP_INSTR (NOP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .freeze       (freeze),
      .branch_taken (branch_taken),
      .branch_adr   (branch_adr),
      .inst_adr     (inst_adr),
      .inst_data    (inst_data),
      .if_pc        (if_pc),
      .if_instr     (if_instr),
      .if_valid     (if_valid)
`ifdef IF_PERF_CNT_EN
      ,
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory: decodes adr[15:0], returns word combinationally.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a[15:0])
         16'h0000: return 32'hE3A0_0001;
         16'h0004: return 32'hE3A0_1002;
         16'h0008: return 32'hE081_2001;
         default:  return {~a[15:0], a[15:0]} ^ 32'h5A3C_0000;
      endcase
   endfunction

   always_comb inst_data = mem_word(inst_adr);

   // Apply one edge's worth of inputs and advance the model by the fetch rules.
   task automatic step(input logic r, input logic f, input logic b, input logic [31:0] ba);
      @(negedge clk);
      rst = r; freeze = f; branch_taken = b; branch_adr = ba;
      @(posedge clk);
      if (r) begin
         m_pc = RST_PC; m_ifpc = 0; m_instr = NOP; m_valid = 0;
         m_fetch = 0; m_flush = 0;
      end else if (b) begin
         m_pc = {ba[31:2], 2'b00}; m_ifpc = 0; m_instr = NOP; m_valid = 0;
         m_flush = m_flush + 1;
      end else if (!f) begin
         m_instr = mem_word(m_pc);
         m_pc    = m_pc + 32'd4;
         m_ifpc  = m_pc;
         m_valid = 1;
         m_fetch = m_fetch + 1;
      end
      #1;
   endtask

   task automatic test_reset;
      step(1, 0, 0, 0);
      step(1, 1, 1, 32'h0000_1234);
      tests++;
      if ({inst_adr, if_pc, if_instr, if_valid} !== {RST_PC, 32'h0, NOP, 1'b0}) begin
         fails++;
         $display("FAIL reset_state got adr=%h pc=%h instr=%h v=%b", inst_adr, if_pc, if_instr, if_valid);
      end
      step(0, 0, 0, 0);
      tests++;
      if ({inst_adr, if_pc, if_instr, if_valid} !== {32'h4, 32'h4, 32'hE3A0_0001, 1'b1}) begin
         fails++;
         $display("FAIL reset_release got adr=%h pc=%h instr=%h v=%b exp 4/4/e3a00001/1", inst_adr, if_pc, if_instr, if_valid);
      end
   endtask

   task automatic test_straight_line;
      logic [31:0] exp_i [3];
      exp_i[0] = 32'hE3A0_0001; exp_i[1] = 32'hE3A0_1002; exp_i[2] = 32'hE081_2001;
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0);
         tests++;
         if (if_instr !== exp_i[i] || if_pc !== 32'(4 * (i + 1)) || if_valid !== 1'b1) begin
            fails++;
            $display("FAIL straight_%0d got instr=%h pc=%h v=%b exp instr=%h pc=%h", i, if_instr, if_pc, if_valid, exp_i[i], 4 * (i + 1));
         end
      end
   endtask

   task automatic test_freeze;
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 0, 0);
         tests++;
         if ({inst_adr, if_pc, if_instr, if_valid} !== {32'h8, 32'h8, 32'hE3A0_1002, 1'b1}) begin
            fails++;
            $display("FAIL freeze_hold_%0d got adr=%h pc=%h instr=%h v=%b", i, inst_adr, if_pc, if_instr, if_valid);
         end
      end
      step(0, 0, 0, 0);
      tests++;
      if (if_instr !== 32'hE081_2001 || if_pc !== 32'hC || inst_adr !== 32'hC) begin
         fails++;
         $display("FAIL freeze_release got instr=%h pc=%h adr=%h exp e0812001/c/c", if_instr, if_pc, inst_adr);
      end
   endtask

   task automatic test_branch_vs_freeze;
      step(0, 1, 1, 32'h0000_0103);
      tests++;
      if ({inst_adr, if_pc, if_instr, if_valid} !== {32'h100, 32'h0, NOP, 1'b0}) begin
         fails++;
         $display("FAIL branch_freeze got adr=%h pc=%h instr=%h v=%b exp 100/0/nop/0", inst_adr, if_pc, if_instr, if_valid);
      end
      step(0, 0, 0, 0);
      tests++;
      if (if_instr !== mem_word(32'h100) || if_pc !== 32'h104 || if_valid !== 1'b1) begin
         fails++;
         $display("FAIL branch_refill got instr=%h pc=%h v=%b exp %h/104/1", if_instr, if_pc, if_valid, mem_word(32'h100));
      end
   endtask

   task automatic test_wrap;
      step(0, 0, 1, 32'hFFFF_FFFE);
      tests++;
      if (inst_adr !== 32'hFFFF_FFFC || if_valid !== 1'b0) begin
         fails++;
         $display("FAIL wrap_branch got adr=%h v=%b exp fffffffc/0", inst_adr, if_valid);
      end
      step(0, 0, 0, 0);
      tests++;
      if ({inst_adr, if_pc, if_instr, if_valid} !== {32'h0, 32'h0, mem_word(32'hFFFF_FFFC), 1'b1}) begin
         fails++;
         $display("FAIL wrap_advance got adr=%h pc=%h instr=%h v=%b", inst_adr, if_pc, if_instr, if_valid);
      end
      step(0, 0, 0, 0);
      step(1, 0, 1, 32'h0000_0400);
      tests++;
      if ({inst_adr, if_pc, if_instr, if_valid} !== {RST_PC, 32'h0, NOP, 1'b0}) begin
         fails++;
         $display("FAIL rst_over_branch got adr=%h pc=%h instr=%h v=%b", inst_adr, if_pc, if_instr, if_valid);
      end
   endtask

   task automatic test_random;
      logic r, f, b;
      logic [31:0] ba;
      step(1, 0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         r  = ($urandom_range(0, 99) < 3);
         f  = ($urandom_range(0, 99) < 25);
         b  = ($urandom_range(0, 99) < 10);
         ba = $urandom;
         step(r, f, b, ba);
         tests++;
         if ({inst_adr, if_pc, if_instr, if_valid} !== {m_pc, m_ifpc, m_instr, m_valid}) begin
            fails++;
            $display("FAIL random_%0d got adr=%h pc=%h instr=%h v=%b exp adr=%h pc=%h instr=%h v=%b",
                     i, inst_adr, if_pc, if_instr, if_valid, m_pc, m_ifpc, m_instr, m_valid);
         end
`ifdef IF_PERF_CNT_EN
         tests++;
         if (perf_fetch_cnt !== m_fetch || perf_flush_cnt !== m_flush) begin
            fails++;
            $display("FAIL random_perf_%0d got fetch=%0d flush=%0d exp %0d/%0d", i, perf_fetch_cnt, perf_flush_cnt, m_fetch, m_flush);
         end
`endif
      end
   endtask

`ifdef IF_PERF_CNT_EN
   task automatic test_perf_cnt;
      step(1, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0);
      step(0, 0, 1, 32'h0000_0200);
      step(0, 1, 1, 32'h0000_0300);
      tests++;
      if (perf_fetch_cnt !== 32'd10 || perf_flush_cnt !== 32'd2) begin
         fails++;
         $display("FAIL perf_counts got fetch=%0d flush=%0d exp 10/2", perf_fetch_cnt, perf_flush_cnt);
      end
      step(1, 0, 1, 0);
      tests++;
      if (perf_fetch_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin
         fails++;
         $display("FAIL perf_reset got fetch=%0d flush=%0d exp 0/0", perf_fetch_cnt, perf_flush_cnt);
      end
   endtask
`endif

   initial begin
      tests = 0; fails = 0;
      rst = 1; freeze = 0; branch_taken = 0; branch_adr = 0;
      m_pc = RST_PC; m_ifpc = 0; m_instr = NOP; m_valid = 0; m_fetch = 0; m_flush = 0;
      test_reset();
      test_straight_line();
      test_freeze();
      test_branch_vs_freeze();
      test_wrap();
      test_random();
`ifdef IF_PERF_CNT_EN
      test_perf_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
